// File: rtl/n64_pkg.sv
// ---------------------------------------------------------------------------
// n64_pkg
// Shared definitions for the N64 console-side poll transmitter:
//   - n64_state_t : transmitter FSM states (GUARD only reachable when the
//                   N64_TX_GUARD_EN build macro is defined)
//   - CMD_*       : well-known controller command bytes
//   - QUARTERS_PER_BIT / STOP_QUARTERS : 1 us quarter-cells per data/stop bit
//   - cell_drive(): pad drive level for a given quarter of a data bit
// ---------------------------------------------------------------------------
package n64_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIT    = 3'd1,
        STOP   = 3'd2,
        FINISH = 3'd3,
        GUARD  = 3'd4
    } n64_state_t;

    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    localparam int QUARTERS_PER_BIT = 4;
    localparam int STOP_QUARTERS    = 3;

    // Open-drain drive for one quarter of a data cell (1 = pull low).
    // Quarter 0 always low, quarter 3 always released, the middle two
    // carry the data: low for a 0, released for a 1.
    function automatic logic cell_drive(input logic [1:0] quarter,
                                        input logic       bit_val);
        logic drive;
        case (quarter)
            2'd0:       drive = 1'b1;
            2'd1, 2'd2: drive = ~bit_val;
            default:    drive = 1'b0;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/n64_us_tick.sv
// ---------------------------------------------------------------------------
// n64_us_tick
// Free-running 0..US_TICKS-1 counter producing one quarter-cell timebase.
// Ports:
//   clock : clock, rising edge
//   reset : synchronous active-high reset (counter to 0)
//   clear : synchronous restart of the count (phase-aligns to a new frame)
//   tick  : high for one cycle while the count sits at US_TICKS-1
// ---------------------------------------------------------------------------
module n64_us_tick #(
    parameter int US_TICKS = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int TW = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;

    logic [TW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == TW'(US_TICKS - 1));
    assign tick   = w_last;

    // Quarter-cell counter: restart on reset/clear, wrap after US_TICKS cycles.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= {TW{1'b0}};
        end else if (w_last) begin
            r_count <= {TW{1'b0}};
        end else begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule

// File: rtl/n64_poll_transmitter.sv
// ---------------------------------------------------------------------------
// n64_poll_transmitter
// Console-side serialiser for the N64 one-wire controller bus. Sends an
// 8-bit command MSB first plus a console stop bit using 4-quarter bit cells,
// then pulses done/rx_enable to arm the serial-to-parallel receiver.
//
// Parameters:
//   US_TICKS : clock cycles per 1 us quarter-cell (>= 2)
//   RESP_US  : response guard length in us (only with N64_TX_GUARD_EN)
// Build option:
//   N64_TX_GUARD_EN : after FINISH hold busy (line released) for
//                     RESP_US x US_TICKS cycles so the controller reply
//                     window cannot be trampled by a new request.
// Ports:
//   clock     : clock, rising edge
//   reset     : synchronous active-high reset
//   start     : frame request, only looked at in IDLE
//   cmd[7:0]  : command byte, captured when start is accepted
//   busy      : frame (or guard window) in progress
//   done      : one-cycle pulse at frame end
//   rx_enable : one-cycle pulse with done, to receiver enable_latch
//   data_oe   : 1 = pad pulls the line low, 0 = release
// ---------------------------------------------------------------------------
module n64_poll_transmitter
    import n64_pkg::*;
#(
    parameter int US_TICKS = 12,
    parameter int RESP_US  = 160
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       rx_enable,
    output logic       data_oe
);

    // Parameter sanity: an unsupported setting elaborates this empty marker.
    localparam bit CFG_OK = (US_TICKS >= 2) && (RESP_US >= 1);
    if (!CFG_OK) begin : g_cfg_unsupported
    end

    n64_state_t r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic [1:0] r_quarter;
    logic       r_busy;
    logic       r_done;
    logic       r_rx_enable;
    logic       r_data_oe;
`ifdef N64_TX_GUARD_EN
    logic [15:0] r_guard_cnt;
`endif

    logic w_accept;
    logic w_tick_clear;
    logic w_tick;

    assign w_accept = (r_state == IDLE) && start;
    // Re-phase the timebase at frame start and when leaving FINISH so the
    // guard window is an exact whole number of quarter-cells.
    assign w_tick_clear = w_accept || (r_state == FINISH);

    n64_us_tick #(
        .US_TICKS (US_TICKS)
    ) u_us_tick (
        .clock (clock),
        .reset (reset),
        .clear (w_tick_clear),
        .tick  (w_tick)
    );

    // Transmitter FSM; all outputs are registered next-cycle values so the
    // pad only moves on quarter boundaries.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_quarter   <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rx_enable <= 1'b0;
            r_data_oe   <= 1'b0;
`ifdef N64_TX_GUARD_EN
            r_guard_cnt <= 16'd0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_rx_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= BIT;
                        r_shift   <= cmd;
                        r_bit_idx <= 3'd7;
                        r_quarter <= 2'd0;
                        r_busy    <= 1'b1;
                        r_data_oe <= 1'b1;
                    end else begin
                        r_busy    <= 1'b0;
                        r_data_oe <= 1'b0;
                    end
                end
                BIT: begin
                    if (w_tick) begin
                        if (r_quarter == 2'(QUARTERS_PER_BIT - 1)) begin
                            // Next cell (data or stop) always opens low.
                            r_quarter <= 2'd0;
                            r_data_oe <= 1'b1;
                            if (r_bit_idx == 3'd0) begin
                                r_state <= STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx - 3'd1;
                            end
                        end else begin
                            r_quarter <= r_quarter + 2'd1;
                            r_data_oe <= cell_drive(r_quarter + 2'd1,
                                                    r_shift[r_bit_idx]);
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_quarter == 2'(STOP_QUARTERS - 1)) begin
                            r_state     <= FINISH;
                            r_quarter   <= 2'd0;
                            r_busy      <= 1'b0;
                            r_data_oe   <= 1'b0;
                            r_done      <= 1'b1;
                            r_rx_enable <= 1'b1;
                        end else begin
                            r_quarter <= r_quarter + 2'd1;
                            r_data_oe <= 1'b0;
                        end
                    end
                end
                FINISH: begin
`ifdef N64_TX_GUARD_EN
                    r_state     <= GUARD;
                    r_busy      <= 1'b1;
                    r_guard_cnt <= 16'd0;
`else
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
`endif
                    r_data_oe   <= 1'b0;
                end
`ifdef N64_TX_GUARD_EN
                GUARD: begin
                    r_data_oe <= 1'b0;
                    if (w_tick) begin
                        if (r_guard_cnt == 16'(RESP_US - 1)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_guard_cnt <= r_guard_cnt + 16'd1;
                        end
                    end
                end
`endif
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_data_oe <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rx_enable = r_rx_enable;
    assign data_oe   = r_data_oe;

endmodule

// File: tb/tb_n64_poll_transmitter.sv
// ---------------------------------------------------------------------------
// tb_n64_poll_transmitter
// Directed bench for n64_poll_transmitter at US_TICKS=4 (16-cycle bit cells,
// 140-cycle frame). With N64_TX_GUARD_EN defined, RESP_US=10 gives a
// 40-cycle guard window after done.
// ---------------------------------------------------------------------------
module tb_n64_poll_transmitter;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] cmd;
    logic       busy;
    logic       done;
    logic       rx_enable;
    logic       data_oe;

    int total;
    int bad;

    n64_poll_transmitter #(
        .US_TICKS (4),
        .RESP_US  (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cmd       (cmd),
        .busy      (busy),
        .done      (done),
        .rx_enable (rx_enable),
        .data_oe   (data_oe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected pad drive in frame cycle c (1..140) for command byte cb:
    // bit cells of 16 cycles MSB first, then a 12-cycle stop bit.
    function automatic logic exp_oe(input logic [7:0] cb, input int c);
        int   pos;
        logic b;
        if (c <= 128) begin
            pos = (c - 1) % 16;
            b   = cb[7 - ((c - 1) / 16)];
            return (pos < 4) || ((pos < 12) && (b == 1'b0));
        end else begin
            pos = c - 129;
            return (pos < 4);
        end
    endfunction

    // Called while in cycle 1 of an accepted frame. Checks the 140 frame
    // cycles, the done cycle, any guard window, and ends in the first IDLE
    // cycle. inject_at>0 pulses start with cmd=0x00 in that frame cycle.
    task automatic check_frame(input logic [7:0] cb, input int inject_at,
                               input string name);
        for (int c = 1; c <= 140; c++) begin
            total++;
            if (data_oe !== exp_oe(cb, c)) begin
                bad++;
                $display("FAIL %s oe cyc=%0d got=%b exp=%b", name, c, data_oe, exp_oe(cb, c));
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || rx_enable !== 1'b0) begin
                bad++;
                $display("FAIL %s busy/done cyc=%0d got=%b%b%b exp=100", name, c, busy, done, rx_enable);
            end
            if (inject_at > 0 && c == inject_at) begin
                start = 1'b1;
                cmd   = 8'h00;
            end else if (inject_at > 0 && c == inject_at + 1) begin
                start = 1'b0;
            end
            step();
        end
        total++;
        if (done !== 1'b1 || rx_enable !== 1'b1 || busy !== 1'b0 || data_oe !== 1'b0) begin
            bad++;
            $display("FAIL %s finish done/rx/busy/oe got=%b%b%b%b exp=1100", name, done, rx_enable, busy, data_oe);
        end
        step();
`ifdef N64_TX_GUARD_EN
        for (int g = 0; g < 40; g++) begin
            total++;
            if (busy !== 1'b1 || data_oe !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s guard cyc=%0d busy/oe/done got=%b%b%b exp=100", name, g, busy, data_oe, done);
            end
            step();
        end
`endif
        total++;
        if (busy !== 1'b0 || data_oe !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle busy/oe/done got=%b%b%b exp=000", name, busy, data_oe, done);
        end
    endtask

    // Present a one-cycle start; returns in cycle 1 of the frame.
    task automatic start_frame(input logic [7:0] cb);
        cmd   = cb;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        cmd   = 8'h00;
        step();
        step();
        reset = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b exp=0", done); end
        total++;
        if (rx_enable !== 1'b0) begin bad++; $display("FAIL reset rx_enable got=%b exp=0", rx_enable); end
        total++;
        if (data_oe !== 1'b0) begin bad++; $display("FAIL reset data_oe got=%b exp=0", data_oe); end
    endtask

    task automatic test_poll();
        start_frame(8'h01);
        check_frame(8'h01, 0, "poll");
    endtask

    task automatic test_all_ones();
        start_frame(8'hFF);
        check_frame(8'hFF, 0, "ones");
    endtask

    task automatic test_ignored_start();
        int extra;
        extra = 0;
        start_frame(8'h01);
        check_frame(8'h01, 30, "ignored");
        for (int i = 0; i < 150; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            step();
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ignored extra activity cycles got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        extra = 0;
        start_frame(8'h01);
        for (int c = 1; c < 50; c++) step();
        total++;
        if (data_oe !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid cyc50 oe/busy got=%b%b exp=11", data_oe, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (data_oe !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid cyc51 oe/busy got=%b%b exp=00", data_oe, busy);
        end
        for (int i = 0; i < 150; i++) begin
            if (done === 1'b1 || rx_enable === 1'b1 || busy === 1'b1 || data_oe === 1'b1) extra++;
            step();
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL rstmid activity after reset got=%0d exp=0", extra);
        end
        start_frame(8'h01);
        check_frame(8'h01, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        cmd   = 8'h01;
        start = 1'b1;
        step();
        check_frame(8'h01, 0, "b2b_1");
        step();
        check_frame(8'h01, 0, "b2b_2");
        start = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b stays idle busy got=%b exp=0", busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_poll();
        step();
        test_all_ones();
        step();
        test_ignored_start();
        test_reset_mid();
        step();
        test_back_to_back();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
